dffram_2r1w_host: RTL
=====================

Name: dffram_2r1w_host

Overview:
Host-side pin driver for the 64x4 2R1W DFF RAM tile. It accepts write, read and configure commands over a valid/ready interface and drives the tile's ui/uio/rst_n pins with correctly sequenced address, data and w_en. It captures both read ports and returns them over a valid/ready response channel. Bank (addrhi) and read-buffer/write-through settings are latched by the tile only while its reset is low, so this block generates that configuration reset sequence, including automatic bank switching.

Parameters:
RST_CYCLES, 2, cycles ram_rst_n is held low during a configuration sequence (min 1)
RD_WAIT, 1, extra cycles between read address drive and capture (pin/board latency allowance, 0..3)
DEF_BANK, 2'b00, bank programmed by the initial configuration after rst
DEF_FLAGS, 3'b000, initial {write_through, read_buffer_b, read_buffer_a}

Ports:
clk  in  1  clock; also feeds the tile clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 write, 01 dual read, 10 configure, 11 reserved (accepted, no pin activity, no response)
cmd_addr_a  in  6  {bank[1:0], addr_a[3:0]}; write address, or port-A read address
cmd_addr_b  in  4  port-B read address (same bank as cmd_addr_a)
cmd_wdata  in  4  write data; for configure: [2:0] = new flags
rsp_valid  out  1  read response present
rsp_ready  in  1  response consumed when valid&ready
rsp_data_a  out  4  port-A read data
rsp_data_b  out  4  port-B read data
ram_ui  out  8  tile ui_in: [3:0] wdata_a, [7:4] addr_a
ram_uio  out  8  tile uio_in: [3:0] addr_b (bank in [1:0] during config), [4] read_buffer_a, [5] read_buffer_b, [6] write_through, [7] w_en
ram_rst_n  out  1  tile reset, active low
ram_uo  in  8  tile uo_out: [3:0] rdata_a, [7:4] rdata_b

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. All pin outputs are registered.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data_a/b=0, ram_rst_n=0, ram_ui=0, ram_uio={1'b0, DEF_FLAGS, 2'b00, DEF_BANK}. After rst the FSM enters CFG_LOW with bank/flags registers = DEF_BANK/DEF_FLAGS.
- States: CFG_LOW, CFG_HOLD, IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_WAIT, RESP.
- CFG_LOW:
  - ram_rst_n=0; uio[1:0]=bank, uio[3:2]=0, uio[6:4]=flags, uio[7]=0.
  - Held RST_CYCLES cycles, then CFG_HOLD.
- CFG_HOLD: one cycle with ram_rst_n=1 and uio unchanged; w_en stays 0 across the rst_n rise. Next state is IDLE, or the pending command's first state if the sequence was a bank switch.
- IDLE:
  - cmd_ready=1, uio[6:4]=0, w_en=0.
  - On accept, latch all command fields.
  - If op is write or read and the command bank != current bank: update bank, keep flags, and run CFG_LOW->CFG_HOLD before executing the command.
  - Op 10: set bank=cmd_addr_a[5:4] and flags=cmd_wdata[2:0], then run the config sequence; no response.
- Write (WR_SETUP, WR_STROBE, WR_HOLD):
  - WR_SETUP drives addr_a/wdata with w_en=0.
  - WR_STROBE: w_en=1 for exactly one cycle.
  - WR_HOLD: w_en=0, address/data still held.
  - Then IDLE. Accept-to-next-cmd_ready = 4 cycles. No response.
- Read (RD_WAIT, RESP):
  - Drive addr_a and addr_b; w_en=0.
  - Wait 1 + RD_WAIT cycles, plus 1 if the corresponding read_buffer flag is set (use the max of both ports).
  - Then capture ram_uo[3:0]->rsp_data_a and ram_uo[7:4]->rsp_data_b, and enter RESP.
- RESP: rsp_valid=1 and data stable until rsp_ready; cmd_ready=0. On handshake go to IDLE.
- Only one command is in flight; cmd_ready is asserted only in IDLE.
- Tile memory contents survive configuration sequences; only the tile's config latch changes.
- rst asserted in any state (mid-write, mid-read, RESP pending) aborts the operation on the next edge:
  - The pending response is dropped and w_en deasserts.
  - The reset values above apply and a fresh DEF_BANK/DEF_FLAGS configuration runs.
  - A write aborted in WR_STROBE may or may not have landed; the bench must not check it.
- Same-address write then read returns the new data (each command completes before the next is accepted).

Test Plan:
- rst 1 cycle -> ram_rst_n low for exactly 2 cycles with ram_uio=0x00, then high with uio[7]=0; cmd_ready first high on the 4th cycle after rst drops.
- Write 0x05<-0xA, then read a=0x05 b=0x05 -> w_en high exactly 1 cycle; response a=0xA, b=0xA, captured 2 cycles after address drive.
- Write 0x13<-0x7, then read a=0x13 b=0x03 with current bank 0 -> auto config sequence with uio[1:0]=01; response a=0x7, b = contents of 0x13 (both ports in bank 1).
- Configure flags 3'b011, then read -> capture delayed one extra cycle; data is correct. Hold rsp_ready low 5 cycles -> rsp_valid and data held, cmd_ready=0.
- rst asserted during WR_STROBE and during RESP -> w_en=0 and rsp_valid=0 next cycle; configuration resequenced; earlier completed writes read back intact.
- Op 11 -> accepted in 1 cycle, no pin change, no response.

Source files
------------

// File: rtl/dffram_2r1w_host.sv
// Host-side pin sequencer for the 64x4 2R1W DFF RAM tile: runs write/read/configure
// commands on the tile pins and returns dual-port read data over a valid/ready channel.
module dffram_2r1w_host #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned RD_WAIT    = 1,
  parameter logic [1:0]  DEF_BANK   = 2'b00,
  parameter logic [2:0]  DEF_FLAGS  = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_addr_a,
  input  logic [3:0] cmd_addr_b,
  input  logic [3:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data_a,
  output logic [3:0] rsp_data_b,
  output logic [7:0] ram_ui,
  output logic [7:0] ram_uio,
  output logic       ram_rst_n,
  input  logic [7:0] ram_uo
);

  typedef enum logic [2:0] {
    S_CFG_LOW, S_CFG_HOLD, S_IDLE, S_WR_SETUP,
    S_WR_STROBE, S_WR_HOLD, S_RD_WAIT, S_RESP
  } state_t;

  state_t     r_state;
  logic [1:0] r_bank;
  logic [2:0] r_flags;
  logic [7:0] r_cnt;
  logic       r_pend;
  logic       r_rd;
  logic [3:0] r_addr_a;
  logic [3:0] r_addr_b;
  logic [3:0] r_wdata;

  logic       w_accept;
  logic       w_rw_cmd;
  logic       w_bank_miss;
  logic       w_launch;
  logic       w_l_rd;
  logic [3:0] w_l_addr_a;
  logic [3:0] w_l_addr_b;
  logic [3:0] w_l_wdata;
  logic [1:0] w_cfg_bank;
  logic [2:0] w_cfg_flags;
  logic [7:0] w_rd_cycles;

  assign w_accept    = cmd_valid && cmd_ready;
  assign w_rw_cmd    = w_accept && !cmd_op[1];
  assign w_bank_miss = w_rw_cmd && (cmd_addr_a[5:4] != r_bank);
  assign w_cfg_bank  = cmd_addr_a[5:4];
  assign w_cfg_flags = cmd_op[1] ? cmd_wdata[2:0] : r_flags;

  // A command starts either straight from IDLE or after the bank-switch sequence.
  assign w_launch = (w_rw_cmd && !w_bank_miss) || (r_state == S_CFG_HOLD && r_pend);

  always_comb begin
    w_l_rd     = r_rd;
    w_l_addr_a = r_addr_a;
    w_l_addr_b = r_addr_b;
    w_l_wdata  = r_wdata;
    if (r_state == S_IDLE) begin
      w_l_rd     = cmd_op[0];
      w_l_addr_a = cmd_addr_a[3:0];
      w_l_addr_b = cmd_addr_b;
      w_l_wdata  = cmd_wdata;
    end
  end

  assign w_rd_cycles = 8'(RD_WAIT) + 8'd1 + {7'd0, |r_flags[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CFG_LOW;
      r_bank     <= DEF_BANK;
      r_flags    <= DEF_FLAGS;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_rd       <= 1'b0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_wdata    <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      ram_rst_n  <= 1'b0;
      ram_ui     <= '0;
      ram_uio    <= {1'b0, DEF_FLAGS, 2'b00, DEF_BANK};
    end else begin
      case (r_state)
        S_CFG_LOW: begin
          if (r_cnt == 8'(RST_CYCLES - 1)) begin
            r_state   <= S_CFG_HOLD;
            ram_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_CFG_HOLD: begin
          r_state      <= S_IDLE;
          cmd_ready    <= 1'b1;
          ram_uio[6:4] <= '0;
        end
        S_IDLE: begin
          if (w_accept) begin
            r_rd     <= cmd_op[0];
            r_addr_a <= cmd_addr_a[3:0];
            r_addr_b <= cmd_addr_b;
            r_wdata  <= cmd_wdata;
            if (cmd_op == 2'b10 || w_bank_miss) begin
              r_bank    <= w_cfg_bank;
              r_flags   <= w_cfg_flags;
              r_pend    <= w_bank_miss;
              r_state   <= S_CFG_LOW;
              r_cnt     <= '0;
              cmd_ready <= 1'b0;
              ram_rst_n <= 1'b0;
              ram_uio   <= {1'b0, w_cfg_flags, 2'b00, w_cfg_bank};
            end
          end
        end
        S_WR_SETUP: begin
          r_state     <= S_WR_STROBE;
          ram_uio[7]  <= 1'b1;
        end
        S_WR_STROBE: begin
          r_state     <= S_WR_HOLD;
          ram_uio[7]  <= 1'b0;
        end
        S_WR_HOLD: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        S_RD_WAIT: begin
          if (r_cnt == 8'd0) begin
            rsp_data_a <= ram_uo[3:0];
            rsp_data_b <= ram_uo[7:4];
            rsp_valid  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: r_state <= S_CFG_LOW;
      endcase

      // Placed after the case so it overrides the IDLE/CFG_HOLD defaults above.
      if (w_launch) begin
        cmd_ready <= 1'b0;
        r_pend    <= 1'b0;
        if (w_l_rd) begin
          r_state <= S_RD_WAIT;
          r_cnt   <= w_rd_cycles - 8'd1;
          ram_ui  <= {w_l_addr_a, 4'h0};
          ram_uio <= {4'h0, w_l_addr_b};
        end else begin
          r_state <= S_WR_SETUP;
          ram_ui  <= {w_l_addr_a, w_l_wdata};
          ram_uio <= '0;
        end
      end
    end
  end

endmodule
